// File: rtl/sv32_mmu_walker.sv
// Sv32 translation unit: fully associative TLB plus hardware page-table walker on a request/ack port.
// Latency: bare or TLB hit responds 1 cycle after accept; a miss responds the cycle after the last PTE ack.
// Backpressure: req_ready is high only in IDLE (one translation in flight); a walk waits indefinitely on mem_ack.
//
// Ports:
//   CLOCK_50, KEY0            clock, asynchronous active-low reset
//   satp_mode, satp_ppn       translation enable and root page-table PPN
//   sfence                    invalidate every TLB entry on the next edge
//   req_valid/req_ready       request handshake; req_va, req_write, req_user describe the access
//   resp_valid                one-cycle result pulse with resp_pa / resp_fault (resp_pa is 0 on a fault)
//   mem_rd/mem_addr           PTE read request, held until mem_ack; mem_rdata valid with mem_ack
//
// Optional build macro MMU_AD_CHECK_EN: leaves with A=0, or stores to pages with D=0, fault
// (no hardware A/D update); the D bit is then kept per TLB entry and checked on hits.

module sv32_mmu_walker #(
  parameter int TLB_ENTRIES = 8,
  parameter int PPN_W       = 20
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic             satp_mode,
  input  logic [PPN_W-1:0] satp_ppn,
  input  logic             sfence,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_va,
  input  logic             req_write,
  input  logic             req_user,
  output logic             resp_valid,
  output logic [31:0]      resp_pa,
  output logic             resp_fault,
  output logic             mem_rd,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WALK1 = 2'd1,
    S_WALK0 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request
  logic [31:0] va_q, va_d;
  logic        write_q, write_d;
  logic        user_q, user_d;

  // Registered outputs
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic [31:0] resp_pa_q, resp_pa_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  // Set when an sfence lands after the current walk was accepted: its result must not be cached.
  logic        flush_pend_q;

  // TLB storage
  logic [TLB_ENTRIES-1:0] tlb_valid_q;
  logic [TLB_ENTRIES-1:0] tlb_r_q;
  logic [TLB_ENTRIES-1:0] tlb_w_q;
  logic [TLB_ENTRIES-1:0] tlb_u_q;
  logic [19:0]            tlb_vpn_q [TLB_ENTRIES];
  logic [PPN_W-1:0]       tlb_ppn_q [TLB_ENTRIES];
  logic [IDX_W-1:0]       ptr_q;
`ifdef MMU_AD_CHECK_EN
  logic [TLB_ENTRIES-1:0] tlb_d_q;
`endif

  // PTE field decode of the word returned by memory
  logic             pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
  logic [19:0]      pte_ppn;
  logic             pte_bad, pte_leaf, pte_ad_fault, walk_perm_fault;
  logic             unused_pte_bits;

  assign pte_v   = mem_rdata[0];
  assign pte_r   = mem_rdata[1];
  assign pte_w   = mem_rdata[2];
  assign pte_x   = mem_rdata[3];
  assign pte_u   = mem_rdata[4];
  assign pte_a   = mem_rdata[6];
  assign pte_d   = mem_rdata[7];
  assign pte_ppn = mem_rdata[29:10];
  // RSW, G (and A/D in the default build) carry no meaning here.
  assign unused_pte_bits = ^mem_rdata[9:5];

  // Reserved encodings and PPN bits above the 32-bit physical space are treated as faults.
  assign pte_bad  = !pte_v || (!pte_r && pte_w) || (mem_rdata[31:30] != 2'b00);
  assign pte_leaf = pte_r || pte_x;

`ifdef MMU_AD_CHECK_EN
  assign pte_ad_fault = !pte_a || (write_q && !pte_d);
`else
  assign pte_ad_fault = 1'b0;
`endif

  assign walk_perm_fault = (write_q && !pte_w) || (!write_q && !pte_r) ||
                           (user_q && !pte_u) || pte_ad_fault;

  // TLB lookup against the incoming VA (used only at accept)
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             hit_fault;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (tlb_valid_q[i] && (tlb_vpn_q[i] == req_va[31:12])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

`ifdef MMU_AD_CHECK_EN
  assign hit_fault = (req_write && !tlb_w_q[hit_idx]) || (!req_write && !tlb_r_q[hit_idx]) ||
                     (req_user && !tlb_u_q[hit_idx]) || (req_write && !tlb_d_q[hit_idx]);
`else
  assign hit_fault = (req_write && !tlb_w_q[hit_idx]) || (!req_write && !tlb_r_q[hit_idx]) ||
                     (req_user && !tlb_u_q[hit_idx]);
`endif

  // Fill slot: lowest invalid entry, otherwise the round-robin pointer
  logic             any_free;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] fill_idx;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!tlb_valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign fill_idx = any_free ? free_idx : ptr_q;

  // Next-state / output logic
  logic             accept;
  logic             walk_done, walk_fault;
  logic [PPN_W-1:0] walk_ppn;
  logic             fill_en;

  assign accept = (state_q == S_IDLE) && req_valid;

  always_comb begin
    state_d      = state_q;
    va_d         = va_q;
    write_d      = write_q;
    user_d       = user_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_pa_d    = resp_pa_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    walk_done    = 1'b0;
    walk_fault   = 1'b0;
    walk_ppn     = '0;
    fill_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          va_d    = req_va;
          write_d = req_write;
          user_d  = req_user;
          if (!satp_mode) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_pa_d    = req_va;
          end else if (hit) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = hit_fault;
            resp_pa_d    = hit_fault ? 32'h0 : {tlb_ppn_q[hit_idx], req_va[11:0]};
          end else begin
            state_d    = S_WALK1;
            mem_rd_d   = 1'b1;
            mem_addr_d = {satp_ppn, 12'h000} + {20'h0, req_va[31:22], 2'b00};
          end
        end
      end

      S_WALK1: begin
        if (mem_rd_q && mem_ack) begin
          if (pte_bad) begin
            walk_done  = 1'b1;
            walk_fault = 1'b1;
          end else if (pte_leaf) begin
            // Superpage: low PPN bits must be zero; vpn0 fills them in.
            walk_done  = 1'b1;
            walk_fault = (pte_ppn[9:0] != 10'h0) || walk_perm_fault;
            walk_ppn   = {pte_ppn[19:10], va_q[21:12]};
          end else begin
            // mem_rd stays high; the next read simply targets the level-0 PTE.
            state_d    = S_WALK0;
            mem_addr_d = {pte_ppn, 12'h000} + {20'h0, va_q[21:12], 2'b00};
          end
        end
      end

      S_WALK0: begin
        if (mem_rd_q && mem_ack) begin
          walk_done  = 1'b1;
          walk_fault = pte_bad || !pte_leaf || walk_perm_fault;
          walk_ppn   = pte_ppn;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (walk_done) begin
      state_d      = S_RESP;
      mem_rd_d     = 1'b0;
      resp_valid_d = 1'b1;
      resp_fault_d = walk_fault;
      resp_pa_d    = walk_fault ? 32'h0 : {walk_ppn, va_q[11:0]};
      // A flush seen during this walk, or arriving now, wins over the fill.
      fill_en      = !walk_fault && !flush_pend_q && !sfence;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q      <= S_IDLE;
      va_q         <= '0;
      write_q      <= 1'b0;
      user_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_pa_q    <= '0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      flush_pend_q <= 1'b0;
      ptr_q        <= '0;
      tlb_valid_q  <= '0;
      tlb_r_q      <= '0;
      tlb_w_q      <= '0;
      tlb_u_q      <= '0;
`ifdef MMU_AD_CHECK_EN
      tlb_d_q      <= '0;
`endif
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tlb_vpn_q[i] <= '0;
        tlb_ppn_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      va_q         <= va_d;
      write_q      <= write_d;
      user_q       <= user_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_pa_q    <= resp_pa_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;

      if (accept) flush_pend_q <= 1'b0;
      if (sfence) flush_pend_q <= 1'b1;

      if (fill_en) begin
        tlb_valid_q[fill_idx] <= 1'b1;
        tlb_vpn_q[fill_idx]   <= va_q[31:12];
        tlb_ppn_q[fill_idx]   <= walk_ppn;
        tlb_r_q[fill_idx]     <= pte_r;
        tlb_w_q[fill_idx]     <= pte_w;
        tlb_u_q[fill_idx]     <= pte_u;
`ifdef MMU_AD_CHECK_EN
        tlb_d_q[fill_idx]     <= pte_d;
`endif
        ptr_q                 <= ptr_q + IDX_W'(1);
      end

      if (sfence) tlb_valid_q <= '0;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_pa    = resp_pa_q;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_sv32_mmu_walker.sv
// Directed bench for sv32_mmu_walker: page tables live in a sparse memory model with a 2-cycle ack.
// Every translation is checked for fault, PA, latency (where fixed) and number of PTE reads.
// Summary line counts vectors applied and miscompares.

module tb_sv32_mmu_walker;

  logic        CLOCK_50;
  logic        KEY0;
  logic        satp_mode;
  logic [19:0] satp_ppn;
  logic        sfence;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_va;
  logic        req_write;
  logic        req_user;
  logic        resp_valid;
  logic [31:0] resp_pa;
  logic        resp_fault;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  sv32_mmu_walker #(.TLB_ENTRIES(8), .PPN_W(20)) dut (
    .CLOCK_50  (CLOCK_50),
    .KEY0      (KEY0),
    .satp_mode (satp_mode),
    .satp_ppn  (satp_ppn),
    .sfence    (sfence),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_va    (req_va),
    .req_write (req_write),
    .req_user  (req_user),
    .resp_valid(resp_valid),
    .resp_pa   (resp_pa),
    .resp_fault(resp_fault),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors     = 0;
  int miscompares = 0;
  int rd_cycles   = 0;

  logic [31:0] pt_mem [logic [31:0]];
  logic [31:0] rd_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_pte(input logic [19:0] ppn, input logic [7:0] fl);
    return {2'b00, ppn, 2'b00, fl};
  endfunction

  function automatic logic [31:0] pt_rd(input logic [31:0] a);
    if (pt_mem.exists(a)) return pt_mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] va5(input int i);
    return 32'h0180_0234 | (i << 12);
  endfunction

  function automatic logic [31:0] pa5(input int i);
    return ((32'h10 + i) << 12) | 32'h234;
  endfunction

  always @(posedge CLOCK_50) if (mem_rd) rd_cycles++;

  // Memory responder: ack arrives on the second negedge that sees mem_rd high.
  initial begin
    int cnt;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge CLOCK_50);
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt     = 0;
      end else if (mem_rd && KEY0) begin
        cnt++;
        if (cnt >= 2) begin
          mem_ack   = 1'b1;
          mem_rdata = pt_rd(mem_addr);
          rd_log.push_back(mem_addr);
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic xlate(input logic [31:0] va, input logic wr, input logic usr,
                       output logic [31:0] pa, output logic flt, output int lat);
    int n;
    pa  = 32'h0;
    flt = 1'b0;
    lat = 0;
    n   = 0;
    @(negedge CLOCK_50);
    while (!req_ready && n < 50) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_va    = va;
    req_write = wr;
    req_user  = usr;
    do begin
      @(negedge CLOCK_50);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < 100);
    if (!resp_valid) begin
      check("resp_timeout", 32'h0, 32'h1);
      lat = -1;
    end else begin
      pa  = resp_pa;
      flt = resp_fault;
      @(negedge CLOCK_50);
      check("resp_pulse", {31'h0, resp_valid}, 32'h0);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] va, input logic wr, input logic usr,
                     input logic exp_flt, input logic [31:0] exp_pa, input int exp_lat,
                     input int exp_reads);
    logic [31:0] pa;
    logic        flt;
    int          lat;
    rd_log.delete();
    xlate(va, wr, usr, pa, flt, lat);
    check({tag, ".fault"}, {31'h0, flt}, {31'h0, exp_flt});
    check({tag, ".pa"}, pa, exp_pa);
    if (exp_lat >= 0) check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".reads"}, rd_log.size(), exp_reads);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int snap;
    logic seen;
    KEY0      = 1'b0;
    satp_mode = 1'b0;
    satp_ppn  = 20'h0;
    sfence    = 1'b0;
    req_valid = 1'b0;
    req_va    = 32'h0;
    req_write = 1'b0;
    req_user  = 1'b0;

    // Page tables
    pt_mem[32'h1004] = mk_pte(20'h00002, 8'h01);
    pt_mem[32'h2008] = mk_pte(20'h00005, 8'hC7);
    pt_mem[32'h1008] = mk_pte(20'h00400, 8'hC3);
    pt_mem[32'h100C] = mk_pte(20'h00401, 8'hC3);
    pt_mem[32'h1010] = mk_pte(20'h00800, 8'hC3);
    pt_mem[32'h1014] = mk_pte(20'h00C00, 8'hC3);
    pt_mem[32'h1018] = mk_pte(20'h00003, 8'h01);
    for (int i = 0; i < 9; i++) pt_mem[32'h3000 + 4 * i] = mk_pte(20'h10 + i, 8'hC7);

    repeat (3) @(negedge CLOCK_50);
    check("rst.req_ready",  {31'h0, req_ready},  32'h1);
    check("rst.resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst.resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst.resp_pa",    resp_pa,             32'h0);
    check("rst.mem_rd",     {31'h0, mem_rd},     32'h0);
    check("rst.mem_addr",   mem_addr,            32'h0);
    KEY0 = 1'b1;

    // 1: bare mode
    snap = rd_cycles;
    run("bare", 32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 1, 0);
    check("bare.mem_rd_cycles", rd_cycles - snap, 0);

    satp_mode = 1'b1;
    satp_ppn  = 20'h00001;

    // 2: two-level walk then hit
    run("walk2", 32'h0040_2ABC, 1'b0, 1'b0, 1'b0, 32'h0000_5ABC, -1, 2);
    check("walk2.addr0", rd_log[0], 32'h0000_1004);
    check("walk2.addr1", rd_log[1], 32'h0000_2008);
    run("hit2", 32'h0040_2ABC, 1'b0, 1'b0, 1'b0, 32'h0000_5ABC, 1, 0);

    // 3: superpage and misaligned superpage
    run("super", 32'h0080_3123, 1'b0, 1'b0, 1'b0, 32'h0040_3123, -1, 1);
    check("super.addr0", rd_log[0], 32'h0000_1008);
    run("misalign", 32'h00C0_3123, 1'b0, 1'b0, 1'b1, 32'h0, -1, 1);

    // 4: permission faults
    run("st_ro_walk",  32'h0100_0000, 1'b1, 1'b0, 1'b1, 32'h0, -1, 1);
    run("st_ro_retry", 32'h0100_0000, 1'b1, 1'b0, 1'b1, 32'h0, -1, 1);
    run("ld_ro_walk",  32'h0100_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, -1, 1);
    run("ld_ro_hit",   32'h0100_0000, 1'b0, 1'b0, 1'b0, 32'h0080_0000, 1, 0);
    run("st_ro_hit",   32'h0080_3123, 1'b1, 1'b0, 1'b1, 32'h0, 1, 0);
    run("usr_walk",    32'h0140_0000, 1'b0, 1'b1, 1'b1, 32'h0, -1, 1);
    run("usr_hit",     32'h0040_2ABC, 1'b0, 1'b1, 1'b1, 32'h0, 1, 0);

    // 5: capacity, replacement, sfence
    for (int i = 0; i < 9; i++)
      run($sformatf("fill%0d", i), va5(i), 1'b0, 1'b0, 1'b0, pa5(i), -1, 2);
    run("hit_last", va5(8), 1'b0, 1'b0, 1'b0, pa5(8), 1, 0);
    run("hit_p2",   va5(2), 1'b0, 1'b0, 1'b0, pa5(2), 1, 0);
    run("evict_p0", va5(0), 1'b0, 1'b0, 1'b0, pa5(0), -1, 2);
    @(negedge CLOCK_50);
    sfence = 1'b1;
    @(negedge CLOCK_50);
    sfence = 1'b0;
    run("sfence_p2", va5(2), 1'b0, 1'b0, 1'b0, pa5(2), -1, 2);

    // sfence during a walk: still responds, but no fill
    fork
      run("midflush", va5(3), 1'b0, 1'b0, 1'b0, pa5(3), -1, 2);
      begin
        repeat (3) @(negedge CLOCK_50);
        sfence = 1'b1;
        @(negedge CLOCK_50);
        sfence = 1'b0;
      end
    join
    run("midflush_rewalk", va5(3), 1'b0, 1'b0, 1'b0, pa5(3), -1, 2);

    // 6: reset mid-walk
    @(negedge CLOCK_50);
    req_valid = 1'b1;
    req_va    = va5(4);
    req_write = 1'b0;
    req_user  = 1'b0;
    @(posedge CLOCK_50);
    #1;
    req_valid = 1'b0;
    check("abort.mem_rd_before", {31'h0, mem_rd}, 32'h1);
    KEY0 = 1'b0;
    #1;
    check("abort.mem_rd_async", {31'h0, mem_rd}, 32'h0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge CLOCK_50);
      if (resp_valid) seen = 1'b1;
    end
    KEY0 = 1'b1;
    repeat (4) begin
      @(negedge CLOCK_50);
      if (resp_valid) seen = 1'b1;
    end
    check("abort.no_resp", {31'h0, seen}, 32'h0);
    check("abort.ready", {31'h0, req_ready}, 32'h1);
    run("abort.rewalk", va5(3), 1'b0, 1'b0, 1'b0, pa5(3), -1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
